// File: rtl/dshot_frame_decoder.sv
// DShot receive decoder: measures bit high time against the bit period,
// assembles 16-bit frames and validates the 4-bit checksum.
module dshot_frame_decoder #(
    parameter int BIT_CYCLES = 107,
    parameter int GAP_CYCLES = 214
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable,
    input  logic        dshot_in,
    output logic [10:0] throttle_out,
    output logic        telemetry_out,
    output logic        frame_valid,
    output logic        crc_error,
    output logic        frame_error,
    output logic        busy
);
    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] THRESH   = CW'(BIT_CYCLES >> 1);
    localparam logic [CW-1:0] MIN_HIGH = CW'(BIT_CYCLES >> 3);
    localparam logic [CW-1:0] BIT_C    = CW'(BIT_CYCLES);
    localparam logic [CW-1:0] GAP_C    = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        SYNC_GAP,
        WAIT_START,
        MEASURE_HIGH,
        MEASURE_LOW,
        CHECK
    } state_t;

    state_t        state, state_n;
    logic          sync1, s, s_d;
    logic [CW-1:0] gap_cnt, gap_n;
    logic [CW-1:0] high_cnt, high_n;
    logic [CW-1:0] per_cnt, per_n;
    logic [3:0]    bit_idx, bit_n;
    logic [15:0]   shreg, shreg_n;
    logic [10:0]   thr_n;
    logic          tel_n, fv_n, ce_n, fe_n;
    logic          rise, fall;
    logic [11:0]   crc_v;
    logic [3:0]    crc;

    assign rise  = s & ~s_d;
    assign fall  = ~s & s_d;
    assign crc_v = shreg[15:4] ^ (shreg[15:4] >> 4) ^ (shreg[15:4] >> 8);
    assign crc   = crc_v[3:0];
    assign busy  = (state == MEASURE_HIGH) || (state == MEASURE_LOW)
                || (state == CHECK);

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] x);
        return (x == CNT_MAX) ? x : x + 1'b1;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1         <= 1'b0;
            s             <= 1'b0;
            s_d           <= 1'b0;
            state         <= SYNC_GAP;
            gap_cnt       <= '0;
            high_cnt      <= '0;
            per_cnt       <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            throttle_out  <= '0;
            telemetry_out <= 1'b0;
            frame_valid   <= 1'b0;
            crc_error     <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            sync1         <= dshot_in;
            s             <= sync1;
            s_d           <= s;
            state         <= state_n;
            gap_cnt       <= gap_n;
            high_cnt      <= high_n;
            per_cnt       <= per_n;
            bit_idx       <= bit_n;
            shreg         <= shreg_n;
            throttle_out  <= thr_n;
            telemetry_out <= tel_n;
            frame_valid   <= fv_n;
            crc_error     <= ce_n;
            frame_error   <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        high_n  = high_cnt;
        per_n   = per_cnt;
        bit_n   = bit_idx;
        shreg_n = shreg;
        thr_n   = throttle_out;
        tel_n   = telemetry_out;
        fv_n    = 1'b0;
        ce_n    = 1'b0;
        fe_n    = 1'b0;
        unique case (state)
            SYNC_GAP: begin
                gap_n = s ? '0 : inc(gap_cnt);
                if (gap_cnt >= GAP_C) state_n = WAIT_START;
            end
            WAIT_START: begin
                if (rise) begin
                    high_n  = CW'(1);
                    per_n   = CW'(1);
                    bit_n   = '0;
                    state_n = MEASURE_HIGH;
                end
            end
            MEASURE_HIGH: begin
                high_n = inc(high_cnt);
                per_n  = inc(per_cnt);
                if (fall) begin
                    if (high_cnt < MIN_HIGH) begin
                        fe_n    = 1'b1;
                        gap_n   = '0;
                        state_n = SYNC_GAP;
                    end else begin
                        shreg_n = {shreg[14:0], high_cnt > THRESH};
                        state_n = (bit_idx == 4'd15) ? CHECK : MEASURE_LOW;
                    end
                end else if (high_cnt >= BIT_C) begin
                    fe_n    = 1'b1;
                    gap_n   = '0;
                    state_n = SYNC_GAP;
                end
            end
            MEASURE_LOW: begin
                per_n = inc(per_cnt);
                // A rise wins over a timeout reached in the same cycle.
                if (rise) begin
                    bit_n   = (bit_idx == 4'd15) ? bit_idx : bit_idx + 4'd1;
                    high_n  = CW'(1);
                    per_n   = CW'(1);
                    state_n = MEASURE_HIGH;
                end else if (per_cnt >= GAP_C) begin
                    fe_n    = 1'b1;
                    state_n = WAIT_START;
                end
            end
            CHECK: begin
                if (crc == shreg[3:0]) begin
                    thr_n = shreg[15:5];
                    tel_n = shreg[4];
                    fv_n  = 1'b1;
                end else begin
                    ce_n = 1'b1;
                end
                gap_n   = '0;
                state_n = SYNC_GAP;
            end
            default: begin
                gap_n   = '0;
                state_n = SYNC_GAP;
            end
        endcase
        if (!enable) begin
            state_n = SYNC_GAP;
            gap_n   = '0;
            high_n  = '0;
            per_n   = '0;
            bit_n   = '0;
            fv_n    = 1'b0;
            ce_n    = 1'b0;
            fe_n    = 1'b0;
        end
    end
endmodule

// File: tb/tb_dshot_frame_decoder.sv
// Directed bench for dshot_frame_decoder: frame table plus
// glitch, timeout, overlong, enable and reset sequences.
module tb_dshot_frame_decoder;
    logic        clk_in = 1'b0;
    logic        rst_n_in, enable, dshot_in;
    logic [10:0] throttle_out;
    logic        telemetry_out, frame_valid, crc_error, frame_error, busy;

    dshot_frame_decoder dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable(enable),
        .dshot_in(dshot_in), .throttle_out(throttle_out),
        .telemetry_out(telemetry_out), .frame_valid(frame_valid),
        .crc_error(crc_error), .frame_error(frame_error), .busy(busy)
    );

    always #31 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] frame;
        int          n_valid;
        int          n_crc;
        int          thr;
        int          tel;
    } vec_t;

    vec_t vecs[7];
    int vectors = 0, miscompares = 0;
    int n_fv = 0, n_ce = 0, n_fe = 0;
    int fv0, ce0, fe0;

    always @(negedge clk_in) begin
        if (frame_valid) n_fv++;
        if (crc_error)   n_ce++;
        if (frame_error) n_fe++;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        fv0 = n_fv; ce0 = n_ce; fe0 = n_fe;
    endtask

    task automatic hold(input logic v, input int n);
        dshot_in = v;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_bits(input logic [15:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (f[15-i]) begin hold(1'b1, 80); hold(1'b0, 27); end
            else         begin hold(1'b1, 40); hold(1'b0, 67); end
        end
    endtask

    task automatic send_frame(input logic [15:0] f);
        hold(1'b0, 250);
        send_bits(f, 0, 15);
        hold(1'b0, 30);
    endtask

    task automatic chk_deltas(input string tag, input int fv, input int ce,
                              input int fe);
        chk({tag, " frame_valid"}, n_fv - fv0, fv);
        chk({tag, " crc_error"},   n_ce - ce0, ce);
        chk({tag, " frame_error"}, n_fe - fe0, fe);
    endtask

    initial begin
        vecs[0] = '{16'h82C6, 1, 0, 1046, 0};
        vecs[1] = '{16'h82C7, 0, 1, 1046, 0};
        vecs[2] = '{16'h0617, 1, 0, 48,   1};
        vecs[3] = '{16'hFFFF, 1, 0, 2047, 1};
        vecs[4] = '{16'h0000, 1, 0, 0,    0};
        vecs[5] = '{16'h0022, 1, 0, 1,    0};
        vecs[6] = '{16'hFFFE, 0, 1, 1,    0};

        rst_n_in = 1'b0; enable = 1'b1; dshot_in = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("reset throttle",  throttle_out, 0);
        chk("reset telemetry", telemetry_out, 0);
        chk("reset busy",      busy, 0);
        chk("reset pulses",    {frame_valid, crc_error, frame_error}, 0);
        rst_n_in = 1'b1;

        foreach (vecs[k]) begin
            snap();
            send_frame(vecs[k].frame);
            chk_deltas($sformatf("vec%0d", k), vecs[k].n_valid,
                       vecs[k].n_crc, 0);
            chk($sformatf("vec%0d throttle", k), throttle_out, vecs[k].thr);
            chk($sformatf("vec%0d telemetry", k), telemetry_out, vecs[k].tel);
        end

        // glitch, then a frame without a full gap is ignored
        snap();
        hold(1'b0, 250); hold(1'b1, 5); hold(1'b0, 50);
        send_bits(16'h0617, 0, 15); hold(1'b0, 30);
        chk_deltas("glitch", 0, 0, 1);
        chk("glitch throttle", throttle_out, 1);
        snap();
        send_frame(16'h0617);
        chk_deltas("post-glitch", 1, 0, 0);
        chk("post-glitch throttle", throttle_out, 48);

        // mid-frame timeout re-arms without a gap
        snap();
        hold(1'b0, 250);
        send_bits(16'h82C6, 0, 7);
        hold(1'b0, 200);
        chk_deltas("timeout", 0, 0, 1);
        send_bits(16'h82C6, 0, 15); hold(1'b0, 30);
        chk_deltas("timeout+frame", 1, 0, 1);
        chk("timeout throttle", throttle_out, 1046);

        // overlong high
        snap();
        hold(1'b0, 250); hold(1'b1, 50);
        chk("overlong busy mid", busy, 1);
        hold(1'b1, 70); hold(1'b0, 5);
        chk_deltas("overlong", 0, 0, 1);
        chk("overlong busy after", busy, 0);

        // enable dropped mid-frame
        snap();
        hold(1'b0, 250);
        send_bits(16'h0617, 0, 5);
        enable = 1'b0;
        send_bits(16'h0617, 6, 15);
        hold(1'b0, 30);
        enable = 1'b1;
        hold(1'b0, 30);
        chk_deltas("enable", 0, 0, 0);
        chk("enable throttle", throttle_out, 1046);

        // async reset during bit 10
        hold(1'b0, 250);
        send_bits(16'h82C6, 0, 9);
        hold(1'b1, 20);
        rst_n_in = 1'b0;
        #1;
        chk("async rst throttle", throttle_out, 0);
        chk("async rst busy", busy, 0);
        hold(1'b0, 10);
        rst_n_in = 1'b1;
        snap();
        send_frame(16'h82C6);
        chk_deltas("after reset", 1, 0, 0);
        chk("after reset throttle", throttle_out, 1046);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
